// File: rtl/instruction_decode.sv
// RV32I instruction decoder with a registered 2-entry skid buffer on its output.
// Build option: define DECODE_SYSTEM_EN to accept MISC-MEM/SYSTEM words as legal NOPs.
module instruction_decode (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instruction_i,
    input  logic [31:0] instr_pc_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [4:0]  address_a_o,
    output logic [4:0]  address_b_o,
    output logic [4:0]  address_d_o,
    output logic        reg_write_enable_o,
    output logic [31:0] immediate_o,
    output logic [3:0]  alu_op_o,
    output logic        alu_src_imm_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        branch_o,
    output logic        jump_o,
    output logic [31:0] dec_pc_o,
    output logic        illegal_o
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
`ifdef DECODE_SYSTEM_EN
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
`endif

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

    typedef struct packed {
        logic [4:0]  addr_a;
        logic [4:0]  addr_b;
        logic [4:0]  addr_d;
        logic        rwe;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        alu_src_imm;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [31:0] pc;
    } bundle_t;

    // funct3 maps onto AluOp codes; alt picks SUB/SRA over ADD/SRL
    function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? 4'd1 : 4'd0;
            3'b001:  return 4'd2;
            3'b010:  return 4'd3;
            3'b011:  return 4'd4;
            3'b100:  return 4'd5;
            3'b101:  return alt ? 4'd7 : 4'd6;
            3'b110:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd, rs1, rs2;
    assign opcode = instruction_i[6:0];
    assign rd     = instruction_i[11:7];
    assign funct3 = instruction_i[14:12];
    assign rs1    = instruction_i[19:15];
    assign rs2    = instruction_i[24:20];
    assign funct7 = instruction_i[31:25];

    bundle_t dec;
    logic    legal, writes_rd, use_a, use_b;

    always_comb begin
        dec       = '0;
        legal     = 1'b0;
        writes_rd = 1'b0;
        use_a     = 1'b0;
        use_b     = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal = 1'b1; writes_rd = 1'b1;
                dec.imm = {instruction_i[31:12], 12'b0};
                dec.alu_op = ALU_PASSB; dec.alu_src_imm = 1'b1;
            end
            OPC_AUIPC: begin
                legal = 1'b1; writes_rd = 1'b1;
                dec.imm = {instruction_i[31:12], 12'b0};
                dec.alu_op = ALU_ADD; dec.alu_src_imm = 1'b1;
            end
            OPC_JAL: begin
                legal = 1'b1; writes_rd = 1'b1; dec.jump = 1'b1;
                dec.imm = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                           instruction_i[20], instruction_i[30:21], 1'b0};
                dec.alu_op = ALU_ADD; dec.alu_src_imm = 1'b1;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000); writes_rd = 1'b1; use_a = 1'b1; dec.jump = 1'b1;
                dec.imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
                dec.alu_op = ALU_ADD; dec.alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
                use_a = 1'b1; use_b = 1'b1; dec.branch = 1'b1;
                dec.imm = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                           instruction_i[30:25], instruction_i[11:8], 1'b0};
                dec.alu_op = ALU_SUB;
            end
            OPC_LOAD: begin
                legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                writes_rd = 1'b1; use_a = 1'b1; dec.mem_read = 1'b1;
                dec.imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
                dec.alu_op = ALU_ADD; dec.alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                legal = (funct3 inside {3'b000, 3'b001, 3'b010});
                use_a = 1'b1; use_b = 1'b1; dec.mem_write = 1'b1;
                dec.imm = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
                dec.alu_op = ALU_ADD; dec.alu_src_imm = 1'b1;
            end
            OPC_OPIMM: begin
                // shift-immediates carry funct7 in imm[11:5]; only SRAI may set imm[10]
                if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else                       legal = 1'b1;
                writes_rd = 1'b1; use_a = 1'b1;
                dec.imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
                dec.alu_op = alu_arith(funct3, (funct3 == 3'b101) && instruction_i[30]);
                dec.alu_src_imm = 1'b1;
            end
            OPC_OP: begin
                legal = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                writes_rd = 1'b1; use_a = 1'b1; use_b = 1'b1;
                dec.alu_op = alu_arith(funct3, instruction_i[30]);
            end
`ifdef DECODE_SYSTEM_EN
            OPC_MISC, OPC_SYSTEM: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end else begin
            dec.addr_a = use_a ? rs1 : 5'd0;
            dec.addr_b = use_b ? rs2 : 5'd0;
            dec.rwe    = writes_rd && (rd != 5'd0);
            dec.addr_d = dec.rwe ? rd : 5'd0;
        end
        dec.pc = instr_pc_i;
    end

    occ_e    state_q, state_d;
    bundle_t head_q, head_d, tail_q, tail_d;
    logic    accept, drain;

    assign instr_ready_o = (state_q != TWO);
    assign dec_valid_o   = (state_q != EMPTY);
    assign accept        = instr_valid_i && instr_ready_o;
    assign drain         = dec_valid_o && dec_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // head always holds the oldest bundle; it is cleared whenever the buffer empties
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: if (accept) begin
                head_d  = dec;
                state_d = ONE;
            end
            ONE: begin
                if (accept && drain) begin
                    head_d = dec;
                end else if (accept) begin
                    tail_d  = dec;
                    state_d = TWO;
                end else if (drain) begin
                    head_d  = '0;
                    state_d = EMPTY;
                end
            end
            TWO: if (drain) begin
                head_d  = tail_q;
                tail_d  = '0;
                state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    assign address_a_o        = head_q.addr_a;
    assign address_b_o        = head_q.addr_b;
    assign address_d_o        = head_q.addr_d;
    assign reg_write_enable_o = head_q.rwe;
    assign immediate_o        = head_q.imm;
    assign alu_op_o           = head_q.alu_op;
    assign alu_src_imm_o      = head_q.alu_src_imm;
    assign mem_read_o         = head_q.mem_read;
    assign mem_write_o        = head_q.mem_write;
    assign branch_o           = head_q.branch;
    assign jump_o             = head_q.jump;
    assign dec_pc_o           = head_q.pc;
    assign illegal_o          = head_q.illegal;
endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode fields, skid-buffer backpressure and async reset.
module tb_instruction_decode;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instruction_i;
    logic [31:0] instr_pc_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [4:0]  address_a_o, address_b_o, address_d_o;
    logic        reg_write_enable_o;
    logic [31:0] immediate_o;
    logic [3:0]  alu_op_o;
    logic        alu_src_imm_o, mem_read_o, mem_write_o, branch_o, jump_o;
    logic [31:0] dec_pc_o;
    logic        illegal_o;

    int passed = 0;
    int total  = 0;

    instruction_decode dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instruction_i(instruction_i), .instr_pc_i(instr_pc_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .address_a_o(address_a_o), .address_b_o(address_b_o), .address_d_o(address_d_o),
        .reg_write_enable_o(reg_write_enable_o), .immediate_o(immediate_o),
        .alu_op_o(alu_op_o), .alu_src_imm_o(alu_src_imm_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .branch_o(branch_o), .jump_o(jump_o),
        .dec_pc_o(dec_pc_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        instr_valid_i = 1'b1;
        instruction_i = ins;
        instr_pc_i    = pc;
        $display("offer pc=0x%08h instr=0x%08h", pc, ins);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0; instr_valid_i = 1'b0; instruction_i = '0; instr_pc_i = '0; dec_ready_i = 1'b0;
        #3;
        chk("rst_dec_valid", dec_valid_o, 0);
        chk("rst_instr_ready", instr_ready_o, 1);
        chk("rst_dec_pc", dec_pc_o, 0);
        chk("rst_imm", immediate_o, 0);
        step();
        chk("rst_hold_valid", dec_valid_o, 0);
        #2 rst_n_i = 1'b1;

        // addi x5,x1,-1
        offer(32'hFFF08293, 32'h100); dec_ready_i = 1'b1;
        step();
        chk("addi_valid", dec_valid_o, 1);
        chk("addi_a", address_a_o, 1);
        chk("addi_d", address_d_o, 5);
        chk("addi_imm", immediate_o, 32'hFFFFFFFF);
        chk("addi_alu", alu_op_o, 0);
        chk("addi_srcimm", alu_src_imm_o, 1);
        chk("addi_rwe", reg_write_enable_o, 1);
        chk("addi_pc", dec_pc_o, 32'h100);
        chk("addi_illegal", illegal_o, 0);

        // sw x2,8(x3)
        offer(32'h0021A423, 32'h104);
        step();
        chk("sw_a", address_a_o, 3);
        chk("sw_b", address_b_o, 2);
        chk("sw_imm", immediate_o, 32'h8);
        chk("sw_memwrite", mem_write_o, 1);
        chk("sw_rwe", reg_write_enable_o, 0);
        chk("sw_d", address_d_o, 0);
        chk("sw_pc", dec_pc_o, 32'h104);

        // add x0,x0,x0
        offer(32'h00000033, 32'h108);
        step();
        chk("addx0_rwe", reg_write_enable_o, 0);
        chk("addx0_illegal", illegal_o, 0);
        chk("addx0_srcimm", alu_src_imm_o, 0);

        // all-zero word
        offer(32'h00000000, 32'h10C);
        step();
        chk("zero_illegal", illegal_o, 1);
        chk("zero_rwe", reg_write_enable_o, 0);
        chk("zero_memread", mem_read_o, 0);
        chk("zero_memwrite", mem_write_o, 0);
        chk("zero_branch", branch_o, 0);
        chk("zero_jump", jump_o, 0);
        chk("zero_valid", dec_valid_o, 1);
        chk("zero_pc", dec_pc_o, 32'h10C);

        // fence
        offer(32'h0FF0000F, 32'h110);
        step();
`ifdef DECODE_SYSTEM_EN
        chk("fence_illegal", illegal_o, 0);
`else
        chk("fence_illegal", illegal_o, 1);
`endif
        chk("fence_rwe", reg_write_enable_o, 0);

        // lui x7,0x12345 : rs1 field nonzero but unused
        offer(32'h123453B7, 32'h114);
        step();
        chk("lui_imm", immediate_o, 32'h12345000);
        chk("lui_alu", alu_op_o, 10);
        chk("lui_a", address_a_o, 0);
        chk("lui_d", address_d_o, 7);

        // bne x3,x4,-8
        offer(32'hFE419CE3, 32'h118);
        step();
        chk("bne_imm", immediate_o, 32'hFFFFFFF8);
        chk("bne_branch", branch_o, 1);
        chk("bne_alu", alu_op_o, 1);
        chk("bne_b", address_b_o, 4);
        chk("bne_rwe", reg_write_enable_o, 0);

        // sub x1,x2,x3
        offer(32'h403100B3, 32'h11C);
        step();
        chk("sub_alu", alu_op_o, 1);
        chk("sub_imm", immediate_o, 0);
        chk("sub_a", address_a_o, 2);
        chk("sub_b", address_b_o, 3);

        // srai x5,x6,3
        offer(32'h40335293, 32'h120);
        step();
        chk("srai_alu", alu_op_o, 7);
        chk("srai_imm", immediate_o, 32'h00000403);
        chk("srai_b", address_b_o, 0);

        instr_valid_i = 1'b0;
        step();
        chk("drain_empty", dec_valid_o, 0);
        chk("drain_rwe", reg_write_enable_o, 0);

        // backpressure: three offers with consumer stalled
        dec_ready_i = 1'b0;
        offer(32'h00100093, 32'h200);
        step();
        chk("bp1_valid", dec_valid_o, 1);
        chk("bp1_ready", instr_ready_o, 1);
        chk("bp1_pc", dec_pc_o, 32'h200);
        offer(32'h00200113, 32'h204);
        step();
        chk("bp2_ready", instr_ready_o, 0);
        chk("bp2_pc", dec_pc_o, 32'h200);
        offer(32'h00300193, 32'h208);
        step();
        chk("bp3_ready", instr_ready_o, 0);
        chk("bp3_pc", dec_pc_o, 32'h200);
        chk("bp3_imm", immediate_o, 1);
        dec_ready_i = 1'b1;
        step();
        chk("bp4_pc", dec_pc_o, 32'h204);
        chk("bp4_d", address_d_o, 2);
        chk("bp4_ready", instr_ready_o, 1);
        step();
        chk("bp5_pc", dec_pc_o, 32'h208);
        chk("bp5_d", address_d_o, 3);
        instr_valid_i = 1'b0;
        step();
        chk("bp6_empty", dec_valid_o, 0);

        // async reset with buffer full
        dec_ready_i = 1'b0;
        offer(32'h00100093, 32'h300);
        step();
        offer(32'h00200113, 32'h304);
        step();
        instr_valid_i = 1'b0;
        chk("full_ready", instr_ready_o, 0);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_valid", dec_valid_o, 0);
        chk("arst_ready", instr_ready_o, 1);
        chk("arst_pc", dec_pc_o, 0);
        chk("arst_rwe", reg_write_enable_o, 0);
        chk("arst_d", address_d_o, 0);
        #1 rst_n_i = 1'b1;
        step();
        step();
        chk("post_rst_valid", dec_valid_o, 0);
        dec_ready_i = 1'b1;
        offer(32'h00300193, 32'h400);
        step();
        chk("post_rst_acc_valid", dec_valid_o, 1);
        chk("post_rst_acc_pc", dec_pc_o, 32'h400);
        chk("post_rst_acc_d", address_d_o, 3);
        instr_valid_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Clock  in  1  single clock; all state updates on rising edge.
REQ-002 ResetN  in  1  asynchronous, active-low reset.
REQ-003 InstrValid  in  1  fetch offers Instruction/InstrPC.
REQ-004 InstrReady  out  1  decoder can accept; transfer when InstrValid&&InstrReady.
REQ-005 Instruction  in  32  RV32I instruction word.
REQ-006 InstrPC  in  32  PC of Instruction.
REQ-007 DecValid  out  1  decoded bundle valid.
REQ-008 DecReady  in  1  consumer takes bundle when DecValid&&DecReady.
REQ-009 AddressA  out  5  rs1 to register file read port A.
REQ-010 AddressB  out  5  rs2 to register file read port B.
REQ-011 AddressD  out  5  rd to register file write port.
REQ-012 RegWriteEnable  out  1  rd write request.
REQ-013 Immediate  out  32  sign-extended immediate.
REQ-014 AluOp  out  4  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10.
REQ-015 AluSrcImm  out  1  ALU operand B = Immediate.
REQ-016 MemRead, MemWrite, Branch, Jump  out  1 each  load, store, conditional branch, JAL/JALR.
REQ-017 DecPC  out  32  PC of decoded instruction.
REQ-018 Illegal  out  1  decoded word is not a supported instruction.

Function
REQ-019 Decode SHALL be registered: bundle appears on outputs the cycle after acceptance (latency 1 when buffer empty).
REQ-020 A 2-entry skid buffer SHALL hold decoded bundles; occupancy states EMPTY, ONE, TWO.
REQ-021 InstrReady SHALL equal (occupancy != TWO), driven from registered occupancy only.
REQ-022 Transitions: accept-only +1; drain-only -1; accept and drain together keeps occupancy; drain from EMPTY impossible since DecValid=0.
REQ-023 DecValid SHALL equal (occupancy != EMPTY); outputs show the oldest entry, in order.
REQ-024 While DecValid&&!DecReady all outputs SHALL hold stable.
REQ-025 Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; Instruction[1:0] must be 2'b11.
REQ-026 Immediate formats I, S, B, U, J per RV32I, sign-extended from bit 31; R-type Immediate = 0.
REQ-027 RegWriteEnable=1 only for DecValid, writing opcode (LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP) and rd != 0; otherwise AddressD=0.
REQ-028 AddressA/AddressB SHALL be Instruction[19:15]/[24:20] for formats using them, else 0.
REQ-029 OP funct7[5] selects SUB/SRA; OP-IMM SRAI via imm[10]; BRANCH uses SUB; LOAD/STORE/JALR/AUIPC use ADD; LUI uses PASSB.
REQ-030 Unsupported word: Illegal=1, RegWriteEnable=MemRead=MemWrite=Branch=Jump=0, still occupies one entry and is passed through in order.

Reset
REQ-031 ResetN low SHALL immediately force occupancy EMPTY, DecValid=0, InstrReady=1, all decoded outputs and DecPC to 0, discarding buffered entries.
REQ-032 First acceptance possible on first rising edge with ResetN high.

Configuration
REQ-033 Macro DECODE_SYSTEM_EN defined: MISC-MEM (0001111) and SYSTEM (1110011) decode as legal NOPs (all enables 0, Illegal=0); undefined: both flagged Illegal per REQ-030.

Verification
REQ-034 Offer 0xFFF08293 (addi x5,x1,-1), DecReady=1 -> next cycle DecValid=1, AddressA=1, AddressD=5, Immediate=0xFFFFFFFF, AluOp=0, AluSrcImm=1, RegWriteEnable=1.
REQ-035 Offer 0x0021A423 (sw x2,8(x3)) -> AddressA=3, AddressB=2, Immediate=0x00000008, MemWrite=1, RegWriteEnable=0, AddressD=0.
REQ-036 DecReady=0, offer three instructions back-to-back -> two accepted, InstrReady=0 from the cycle after second acceptance, outputs stable; raise DecReady -> entries drain in order, third accepted.
REQ-037 Offer 0x00000033 (add x0,x0,x0) -> RegWriteEnable=0, Illegal=0; offer 0x00000000 -> Illegal=1, all enables 0.
REQ-038 Fill buffer to TWO, pulse ResetN low mid-cycle -> DecValid=0 and InstrReady=1 without a clock edge; no stale bundle after release.
REQ-039 Offer 0x0FF0000F (fence) -> Illegal=0 with DECODE_SYSTEM_EN defined, Illegal=1 without.
